muldiv_sequencer: RTL and testbench

Multi-cycle controller for the signed multiply and divide operations selected by ALU control codes 4'b1111 (mult) and 4'b0011 (div). It accepts an operation from the decode stage and runs an iterative shift-add multiply or restoring divide over WIDTH cycles. It writes HI/LO and signals completion through a busy/done handshake, which the pipeline uses to stall mfhi/mflo and back-to-back mult/div.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/muldiv_sequencer.sv | 155 +++++++++++++++
 tb/tb_muldiv_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: ALU control codes, muldiv FSM encoding, default width.
package mips_pkg;

  localparam int unsigned MD_WIDTH = 32;

  localparam logic [3:0] ALU_CTRL_AND  = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR   = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD  = 4'b0010;
  localparam logic [3:0] ALU_CTRL_DIV  = 4'b0011;
  localparam logic [3:0] ALU_CTRL_SUB  = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT  = 4'b0111;
  localparam logic [3:0] ALU_CTRL_NOR  = 4'b1100;
  localparam logic [3:0] ALU_CTRL_MULT = 4'b1111;

  localparam logic [1:0] MD_IDLE = 2'd0;
  localparam logic [1:0] MD_MUL  = 2'd1;
  localparam logic [1:0] MD_DIV  = 2'd2;
  localparam logic [1:0] MD_FIX  = 2'd3;

endpackage

// File: rtl/muldiv_sequencer.sv
// Iterative signed mult (shift-add) / div (restoring) on operand magnitudes, WIDTH steps
// plus one sign-fix cycle; busy/done handshake for the pipeline stall logic.
module muldiv_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH    = MD_WIDTH,
  parameter logic [3:0]  ALU_MULT = ALU_CTRL_MULT,
  parameter logic [3:0]  ALU_DIV  = ALU_CTRL_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [1:0]       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d, sr_q, sr_d, mag_b_q, mag_b_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             is_div_q, is_div_d, neg_res_q, neg_res_d, neg_a_q, neg_a_d;
  logic             dbz_q, dbz_d, done_q, done_d, dz_out_q, dz_out_d;

  logic [WIDTH:0]     add_a, add_b, add_sum;
  logic               add_sub;
  logic [2*WIDTH-1:0] prod, prod_s;
  logic               accept, req_div;
  logic [WIDTH-1:0]   mag_a_in, mag_b_in;

  // One adder serves both: accumulate in MUL, trial-subtract of the shifted remainder in DIV.
  always_comb begin
    add_sub = (state_q == MD_DIV);
    if (add_sub) begin
      add_a = {acc_q, sr_q[WIDTH-1]};
      add_b = ~{1'b0, mag_b_q};
    end else begin
      add_a = {1'b0, acc_q};
      add_b = sr_q[0] ? {1'b0, mag_b_q} : '0;
    end
  end
  assign add_sum = add_a + add_b + {{WIDTH{1'b0}}, add_sub};

  assign req_div  = (alu_ctrl == ALU_DIV);
  assign accept   = start && (state_q == MD_IDLE) && ((alu_ctrl == ALU_MULT) || req_div);
  assign mag_a_in = op_a[WIDTH-1] ? ('0 - op_a) : op_a;
  assign mag_b_in = op_b[WIDTH-1] ? ('0 - op_b) : op_b;
  assign prod     = {acc_q, sr_q};
  assign prod_s   = neg_res_q ? ('0 - prod) : prod;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    sr_d      = sr_q;
    mag_b_d   = mag_b_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_a_d   = neg_a_q;
    dbz_d     = dbz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dz_out_d  = dz_out_q;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          acc_d     = '0;
          sr_d      = mag_a_in;
          mag_b_d   = mag_b_in;
          is_div_d  = req_div;
          neg_res_d = op_a[WIDTH-1] ^ op_b[WIDTH-1];
          neg_a_d   = op_a[WIDTH-1];
          dbz_d     = req_div && (op_b == '0);
          cnt_d     = CW'(WIDTH - 1);
          if (req_div && (op_b == '0)) state_d = MD_FIX;
          else if (req_div)            state_d = MD_DIV;
          else                         state_d = MD_MUL;
        end
      end
      MD_MUL: begin
        acc_d = add_sum[WIDTH:1];
        sr_d  = {add_sum[0], sr_q[WIDTH-1:1]};
        if (cnt_q == '0) state_d = MD_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      MD_DIV: begin
        // Negative trial result means restore: keep the shifted remainder, quotient bit 0.
        acc_d = add_sum[WIDTH] ? add_a[WIDTH-1:0] : add_sum[WIDTH-1:0];
        sr_d  = {sr_q[WIDTH-2:0], ~add_sum[WIDTH]};
        if (cnt_q == '0) state_d = MD_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d  = MD_IDLE;
        done_d   = 1'b1;
        dz_out_d = dbz_q;
        if (!dbz_q) begin
          if (is_div_q) begin
            lo_d = neg_res_q ? ('0 - sr_q) : sr_q;
            hi_d = neg_a_q ? ('0 - acc_q) : acc_q;
          end else begin
            {hi_d, lo_d} = prod_s;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= MD_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      sr_q      <= '0;
      mag_b_q   <= '0;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_a_q   <= 1'b0;
      dbz_q     <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      dz_out_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      sr_q      <= sr_d;
      mag_b_q   <= mag_b_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_a_q   <= neg_a_d;
      dbz_q     <= dbz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      dz_out_q  <= dz_out_d;
    end
  end

  assign busy        = (state_q != MD_IDLE);
  assign done        = done_q;
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dz_out_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: hand-computed HI/LO, latency and handshake checks.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  alu_ctrl;
  logic [31:0] op_a, op_b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  localparam logic [3:0] C_MULT = 4'b1111;
  localparam logic [3:0] C_DIV  = 4'b0011;

  muldiv_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .alu_ctrl(alu_ctrl),
    .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
    .hi(hi), .lo(lo), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the falling edge just after the accepting edge.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; alu_ctrl = c; op_a = a; op_b = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int bc);
    n = 0; bc = 0;
    while (done !== 1'b1 && n < 100) begin
      if (busy === 1'b1) bc++;
      @(negedge clk);
      n++;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; alu_ctrl = 4'b0000; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL reset_hilo: got %h expected 0", {hi, lo}); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mult_basic;
    int n, bc;
    issue(C_MULT, 32'h0000_0007, 32'hFFFF_FFFD);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL mult_latency: got %0d expected 33", n); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles: got %0d expected 33", bc); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mult_busy_at_done: got %b expected 0", busy); end
    checks++; if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFEB) begin errors++; $display("FAIL mult_7x-3: got %h expected ffffffffffffffeb", {hi, lo}); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b expected 0", done); end
  endtask

  task automatic test_div_basic;
    int n, bc;
    issue(C_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL div_latency: got %0d expected 33", n); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_-7/2_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_-7/2_hi: got %h expected ffffffff", hi); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL div_-7/2_dbz: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_mult_neg1;
    int n, bc;
    issue(C_MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(n, bc);
    checks++; if ({hi, lo} !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL mult_-1x-1: got %h expected 1", {hi, lo}); end
  endtask

  task automatic test_div_by_zero;
    int n, bc;
    issue(C_DIV, 32'h0000_1234, 32'h0000_0000);
    wait_done(n, bc);
    checks++; if (n !== 1) begin errors++; $display("FAIL dbz_latency: got %0d expected 1", n); end
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b expected 1", div_by_zero); end
    checks++; if ({hi, lo} !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL dbz_hilo_kept: got %h expected 1", {hi, lo}); end
    repeat (3) @(negedge clk);
    checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag_hold: got %b expected 1", div_by_zero); end
  endtask

  task automatic test_overflow;
    int n, bc;
    issue(C_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n, bc);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo: got %h expected 80000000", lo); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi: got %h expected 0", hi); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL ovf_dbz_cleared: got %b expected 0", div_by_zero); end
  endtask

  task automatic test_ignored_start;
    int n, bc;
    issue(C_MULT, 32'd5, 32'd6);
    repeat (4) @(negedge clk);
    start = 1'b1; alu_ctrl = C_DIV; op_a = 32'd100; op_b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, bc);
    checks++; if (n + 5 !== 33) begin errors++; $display("FAIL ignored_latency: got %0d expected 33", n + 5); end
    checks++; if ({hi, lo} !== 64'd30) begin errors++; $display("FAIL ignored_result: got %h expected 1e", {hi, lo}); end
  endtask

  task automatic test_bad_ctrl;
    @(negedge clk);
    start = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd9; op_b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL badctrl_busy: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL badctrl_idle: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_reset_mid;
    int n, bc;
    issue(C_DIV, 32'd100, 32'd7);
    repeat (10) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL rstmid_flags: got %b expected 00", {busy, done}); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL rstmid_hilo: got %h expected 0", {hi, lo}); end
    issue(C_MULT, 32'd3, 32'd4);
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL rstmid_mult_latency: got %0d expected 33", n); end
    checks++; if ({hi, lo} !== 64'd12) begin errors++; $display("FAIL rstmid_mult_3x4: got %h expected c", {hi, lo}); end
  endtask

  task automatic test_back_to_back;
    int n, bc;
    issue(C_MULT, 32'd2, 32'd3);
    wait_done(n, bc);
    checks++; if ({hi, lo} !== 64'd6) begin errors++; $display("FAIL b2b_first: got %h expected 6", {hi, lo}); end
    start = 1'b1; alu_ctrl = C_DIV; op_a = 32'd20; op_b = 32'hFFFF_FFFA;
    @(negedge clk);
    start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_busy_rise: got %b expected 1", busy); end
    wait_done(n, bc);
    checks++; if (n !== 33) begin errors++; $display("FAIL b2b_latency: got %0d expected 33", n); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL b2b_div_lo: got %h expected fffffffd", lo); end
    checks++; if (hi !== 32'h0000_0002) begin errors++; $display("FAIL b2b_div_hi: got %h expected 2", hi); end
  endtask

  initial begin
    test_reset();
    test_mult_basic();
    test_div_basic();
    test_mult_neg1();
    test_div_by_zero();
    test_overflow();
    test_ignored_start();
    test_bad_ctrl();
    test_reset_mid();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
